// File: rtl/xbus_initiator.sv
// xbus_initiator: single-outstanding xbus master.
// A CPU load/store request (valid/ready) becomes one xbus transaction. The read data or an error
// comes back on a valid/ready response channel.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   cpu_req_valid/ready/we/addr/be/wdata   CPU request channel
//   cpu_resp_valid/ready/rdata/err         CPU response channel
//   xbus_as/addr/we/be/wdata          registered xbus request; xbus_as is high in ADDR and WAIT
//   xbus_cs                           one-hot select from the combinational address decoder
//   xbus_rdata, xbus_rdy              slave read data and completion
//
// Optional feature: define XBUS_TIMEOUT_EN to end a WAIT with a bus error once TIMEOUT cycles
// pass without xbus_rdy. Without it, WAIT holds indefinitely and TIMEOUT is unused.
module xbus_initiator #(
  parameter int unsigned NSLAVES = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req_valid,
  output logic               cpu_req_ready,
  input  logic               cpu_req_we,
  input  logic [31:0]        cpu_req_addr,
  input  logic [3:0]         cpu_req_be,
  input  logic [31:0]        cpu_req_wdata,
  output logic               cpu_resp_valid,
  input  logic               cpu_resp_ready,
  output logic [31:0]        cpu_resp_rdata,
  output logic               cpu_resp_err,
  output logic               xbus_as,
  output logic [31:0]        xbus_addr,
  output logic               xbus_we,
  output logic [3:0]         xbus_be,
  output logic [31:0]        xbus_wdata,
  input  logic [NSLAVES-1:0] xbus_cs,
  input  logic [31:0]        xbus_rdata,
  input  logic               xbus_rdy
);

  typedef enum logic [1:0] {StIdle, StAddr, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic        cs_ok;
  logic        req_fire;
  logic        expired;

  // Exactly one slave selected: non-zero with a single bit set.
  assign cs_ok    = (xbus_cs != '0) && ((xbus_cs & (xbus_cs - NSLAVES'(1))) == '0);
  assign req_fire = cpu_req_valid & cpu_req_ready;

`ifdef XBUS_TIMEOUT_EN
  localparam int unsigned CntRaw = $clog2(TIMEOUT + 1);
  localparam int unsigned CntW   = (CntRaw < 8) ? 8 : ((CntRaw > 16) ? 16 : CntRaw);

  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q counts WAIT cycles already spent without rdy, so the TIMEOUT-th WAIT cycle is the
  // expiry cycle. A slave rdy in that same cycle still wins (checked first in the FSM).
  assign expired = (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StAddr) begin
      cnt_d = '0;
    end else if ((state_q == StWait) && !xbus_rdy) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign expired = 1'b0;

  // TIMEOUT has no effect in this build; referenced here only so it is not a dangling parameter.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    we_d    = we_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (req_fire) begin
          we_d    = cpu_req_we;
          addr_d  = cpu_req_addr;
          be_d    = cpu_req_we ? cpu_req_be : 4'hF;
          wdata_d = cpu_req_wdata;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (!cs_ok) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end else if (xbus_rdy) begin
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : xbus_rdata;
          state_d = StResp;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (xbus_rdy) begin
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : xbus_rdata;
          state_d = StResp;
        end else if (expired) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (cpu_resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // rst_n gates ready so that no request can be seen as accepted while reset is asserted.
  assign cpu_req_ready  = (state_q == StIdle) & rst_n;
  assign cpu_resp_valid = (state_q == StResp);
  assign cpu_resp_rdata = rdata_q;
  assign cpu_resp_err   = err_q;
  assign xbus_as        = (state_q == StAddr) || (state_q == StWait);
  assign xbus_addr      = addr_q;
  assign xbus_we        = we_q;
  assign xbus_be        = be_q;
  assign xbus_wdata     = wdata_q;

endmodule

// File: tb/tb_xbus_initiator.sv
// Self-checking bench for xbus_initiator: directed table, hand-written corner sequences and
// randomized transactions checked against a transaction-level reference model.
module tb_xbus_initiator;

  localparam int unsigned NS = 3;
`ifdef XBUS_TIMEOUT_EN
  localparam int unsigned TMO    = 4;
  localparam bit          TMO_EN = 1'b1;
`else
  localparam int unsigned TMO    = 255;
  localparam bit          TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req_valid = 1'b0;
  logic          cpu_req_ready;
  logic          cpu_req_we = 1'b0;
  logic [31:0]   cpu_req_addr = '0;
  logic [3:0]    cpu_req_be = '0;
  logic [31:0]   cpu_req_wdata = '0;
  logic          cpu_resp_valid;
  logic          cpu_resp_ready = 1'b0;
  logic [31:0]   cpu_resp_rdata;
  logic          cpu_resp_err;
  logic          xbus_as;
  logic [31:0]   xbus_addr;
  logic          xbus_we;
  logic [3:0]    xbus_be;
  logic [31:0]   xbus_wdata;
  logic [NS-1:0] xbus_cs;
  logic [31:0]   xbus_rdata;
  logic          xbus_rdy;

  always #5 clk = ~clk;

  xbus_initiator #(.NSLAVES(NS), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_be     (cpu_req_be),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_ready (cpu_resp_ready),
    .cpu_resp_rdata (cpu_resp_rdata),
    .cpu_resp_err   (cpu_resp_err),
    .xbus_as        (xbus_as),
    .xbus_addr      (xbus_addr),
    .xbus_we        (xbus_we),
    .xbus_be        (xbus_be),
    .xbus_wdata     (xbus_wdata),
    .xbus_cs        (xbus_cs),
    .xbus_rdata     (xbus_rdata),
    .xbus_rdy       (xbus_rdy)
  );

  // Slave/decoder model: select is qualified by xbus_as; rdy rises after wait_cfg strobe cycles.
  // rdy_junk drives rdy while the strobe is low to show it is ignored in IDLE/RESP.
  logic [NS-1:0] cs_cfg = '0;
  int unsigned   wait_cfg = 0;
  logic [31:0]   rdata_cfg = '0;
  logic          rdy_junk = 1'b0;
  int unsigned   as_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) as_cnt <= 0;
    else if (xbus_as) as_cnt <= as_cnt + 1;
    else as_cnt <= 0;
  end

  assign xbus_cs    = xbus_as ? cs_cfg : '0;
  assign xbus_rdy   = (xbus_as && (as_cnt == wait_cfg)) || rdy_junk;
  assign xbus_rdata = rdata_cfg;

  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [NS-1:0] cs;
    int unsigned   wait_n;
    logic [31:0]   rdata;
    int unsigned   hold;
    logic          exp_err;
    logic [31:0]   exp_rd;
    int unsigned   exp_as;
  } txn_t;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level expectation: errors for bad selects and expired waits, else slave data.
  function automatic void model(inout txn_t t);
    if (!((t.cs != '0) && ($countones(t.cs) == 1))) begin
      t.exp_err = 1'b1; t.exp_rd = '0; t.exp_as = 1;
    end else if (TMO_EN && (t.wait_n > TMO)) begin
      t.exp_err = 1'b1; t.exp_rd = '0; t.exp_as = 1 + TMO;
    end else begin
      t.exp_err = 1'b0; t.exp_rd = t.we ? 32'h0 : t.rdata; t.exp_as = 1 + t.wait_n;
    end
  endfunction

  // Called at a negedge: present the request and slave behaviour.
  task automatic drive_req(input txn_t t);
    rdy_junk      = 1'b0;
    cs_cfg        = t.cs;
    wait_cfg      = t.wait_n;
    rdata_cfg     = t.rdata;
    cpu_req_we    = t.we;
    cpu_req_addr  = t.addr;
    cpu_req_be    = t.be;
    cpu_req_wdata = t.wdata;
    cpu_req_valid = 1'b1;
  endtask

  // Wait for acceptance; returns at the negedge of the first ADDR cycle with the request dropped.
  task automatic accept();
    int n = 0;
    while (!cpu_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", {31'b0, cpu_req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_req_addr  = ~cpu_req_addr;
    cpu_req_wdata = ~cpu_req_wdata;
    cpu_req_be    = ~cpu_req_be;
  endtask

  task automatic collect(input txn_t t);
    int unsigned as_n = 0;
    int unsigned lat = 1;
    logic        stable = 1'b1;
    logic [3:0]  exp_be = t.we ? t.be : 4'hF;
    while (!cpu_resp_valid && lat < 600) begin
      if (xbus_as) begin
        as_n++;
        if (xbus_addr !== t.addr || xbus_we !== t.we || xbus_be !== exp_be ||
            xbus_wdata !== t.wdata || cpu_req_ready !== 1'b0) stable = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    chk("resp_seen", {31'b0, cpu_resp_valid}, 32'd1);
    chk("as_cycles", as_n, t.exp_as);
    chk("resp_latency", lat, t.exp_as + 1);
    chk("bus_stable", {31'b0, stable}, 32'd1);
    chk("as_low_in_resp", {31'b0, xbus_as}, 32'd0);
    chk("resp_err", {31'b0, cpu_resp_err}, {31'b0, t.exp_err});
    chk("resp_rdata", cpu_resp_rdata, t.exp_rd);
  endtask

  task automatic hold_resp(input int unsigned n);
    logic [31:0] r0 = cpu_resp_rdata;
    logic        e0 = cpu_resp_err;
    logic        ok = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      rdy_junk = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!cpu_resp_valid || cpu_resp_rdata !== r0 || cpu_resp_err !== e0 ||
          cpu_req_ready || xbus_as) ok = 1'b0;
    end
    rdy_junk = 1'b0;
    chk("resp_hold", {31'b0, ok}, 32'd1);
  endtask

  task automatic finish_resp();
    cpu_resp_ready = 1'b1;
    rdy_junk       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_resp_ready = 1'b0;
    rdy_junk       = 1'b0;
    chk("resp_drop", {31'b0, cpu_resp_valid}, 32'd0);
    chk("idle_ready", {31'b0, cpu_req_ready}, 32'd1);
  endtask

  task automatic run(input txn_t t);
    drive_req(t);
    accept();
    collect(t);
    hold_resp(t.hold);
    finish_resp();
  endtask

  txn_t vecs[8];
  txn_t t, a, b;
  logic [NS-1:0] cs_pick[6];

  initial begin
    // {we, addr, be, wdata, cs, wait_n, rdata, hold, exp_err, exp_rd, exp_as}
    vecs[0] = '{1'b0, 32'h8000_0010, 4'h0, 32'h0, 3'b001, 0, 32'hDEAD_BEEF, 0,
                1'b0, 32'hDEAD_BEEF, 1};
    vecs[1] = '{1'b1, 32'h0000_1004, 4'b0011, 32'h0000_1234, 3'b010, 3, 32'h55AA_55AA, 1,
                1'b0, 32'h0, 4};
    vecs[2] = '{1'b0, 32'h0000_2000, 4'h0, 32'h0, 3'b000, 1000, 32'h1111_2222, 2,
                1'b1, 32'h0, 1};
    vecs[3] = '{1'b0, 32'h0000_3000, 4'h0, 32'h0, 3'b011, 0, 32'h3333_4444, 0,
                1'b1, 32'h0, 1};
    vecs[4] = '{1'b1, 32'h4000_0000, 4'b1000, 32'hCAFE_F00D, 3'b100, 0, 32'h7777_8888, 0,
                1'b0, 32'h0, 1};
    vecs[5] = '{1'b0, 32'h4000_0040, 4'h0, 32'h0, 3'b100, 2, 32'h0BAD_F00D, 3,
                1'b0, 32'h0BAD_F00D, 3};
    vecs[6] = '{1'b0, 32'h2000_0008, 4'h0, 32'h0, 3'b010, 4, 32'hA5A5_0F0F, 0,
                1'b0, 32'hA5A5_0F0F, 5};
    vecs[7] = '{1'b0, 32'h0000_5000, 4'h0, 32'h0, 3'b111, 0, 32'h9999_9999, 0,
                1'b1, 32'h0, 1};
    cs_pick[0] = 3'b001; cs_pick[1] = 3'b010; cs_pick[2] = 3'b100;
    cs_pick[3] = 3'b000; cs_pick[4] = 3'b110; cs_pick[5] = 3'b001;

    // Reset state, including ready forced low while reset is held.
    #2;
    chk("rst_req_ready", {31'b0, cpu_req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, cpu_resp_valid}, 32'd0);
    chk("rst_as", {31'b0, xbus_as}, 32'd0);
    chk("rst_addr", xbus_addr, 32'h0);
    chk("rst_outs", {cpu_resp_err, xbus_we, xbus_be, 26'b0}, 32'h0);
    chk("rst_rdata_wdata", cpu_resp_rdata | xbus_wdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, cpu_req_ready}, 32'd1);

    for (int i = 0; i < 8; i++) run(vecs[i]);

    // Strobe runs out its full wait: timeout expiry, or an indefinite wait without the feature.
    t = '{1'b0, 32'h6000_0000, 4'h0, 32'h0, 3'b001, 1000, 32'h1234_5678, 0, 1'b0, 32'h0, 0};
`ifdef XBUS_TIMEOUT_EN
    t.exp_err = 1'b1; t.exp_rd = 32'h0; t.exp_as = 5;
`else
    t.wait_n = 40; t.exp_err = 1'b0; t.exp_rd = 32'h1234_5678; t.exp_as = 41;
`endif
    run(t);

    // Response stalled 5 cycles, then ready coincides with a new valid request.
    a = '{1'b0, 32'h0000_0100, 4'h0, 32'h0, 3'b010, 1, 32'hFACE_0001, 0, 1'b0, 32'hFACE_0001, 2};
    b = '{1'b1, 32'h0000_0200, 4'b0101, 32'h0BEE_0002, 3'b001, 0, 32'h0, 0, 1'b0, 32'h0, 1};
    drive_req(a);
    accept();
    collect(a);
    hold_resp(5);
    drive_req(b);
    cpu_resp_ready = 1'b1;
    chk("no_accept_in_resp", {31'b0, cpu_req_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    cpu_resp_ready = 1'b0;
    chk("overlap_resp_done", {31'b0, cpu_resp_valid}, 32'd0);
    chk("overlap_idle_ready", {31'b0, cpu_req_ready}, 32'd1);
    chk("overlap_as_low", {31'b0, xbus_as}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    chk("overlap_next_as", {31'b0, xbus_as}, 32'd1);
    chk("overlap_next_addr", xbus_addr, b.addr);
    collect(b);
    finish_resp();

    // Reset asserted mid-WAIT: strobe drops without a clock edge and no response follows.
    t = '{1'b0, 32'h0000_0300, 4'h0, 32'h0, 3'b100, 1000, 32'h0, 0, 1'b0, 32'h0, 0};
    drive_req(t);
    accept();
    @(negedge clk);
    @(negedge clk);
    chk("wait_as_high", {31'b0, xbus_as}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_as_drop", {31'b0, xbus_as}, 32'd0);
    chk("async_ready_low", {31'b0, cpu_req_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_resp_in_rst", {31'b0, cpu_resp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerst_ready", {31'b0, cpu_req_ready}, 32'd1);
    chk("rerst_resp", {31'b0, cpu_resp_valid}, 32'd0);
    chk("rerst_addr", xbus_addr, 32'h0);
    t = '{1'b0, 32'h0001_0000, 4'h0, 32'h0, 3'b001, 1, 32'h0C0F_FEE0, 0, 1'b0, 32'h0, 0};
    model(t);
    run(t);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      t.we     = 1'($urandom_range(0, 1));
      t.addr   = $urandom;
      t.be     = 4'($urandom);
      t.wdata  = $urandom;
      t.cs     = cs_pick[$urandom_range(0, 5)];
      t.wait_n = $urandom_range(0, TMO_EN ? 7 : 6);
      t.rdata  = $urandom;
      t.hold   = $urandom_range(0, 3);
      model(t);
      run(t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
